// File: rtl/ika3012_serial_dac_rx.sv
// Serial DAC receiver: deserializes OPM floating-point frames into two signed 16-bit PCM channels.
// Optional frame-length checking is enabled by defining IKA3012_FRAME_CHECK_EN.
module ika3012_serial_dac_rx (
    input  logic        i_EMUCLK,
    input  logic        i_IC_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_SO,
    input  logic        i_SH1,
    input  logic        i_SH2,
    output logic [15:0] o_CH1,
    output logic [15:0] o_CH2,
    output logic        o_CH1_STB,
    output logic        o_CH2_STB,
    output logic        o_FRAME_ERR
);

    logic        tick;
    logic [15:0] sr_q;
    logic        sh1_q;
    logic        sh2_q;
    logic        fall1;
    logic        fall2;
    logic        latch;
    logic        frame_ok;
    logic        upd1;
    logic        upd2;
    logic [15:0] pcm;
    logic [15:0] ch1_q;
    logic [15:0] ch2_q;
    logic        stb1_q;
    logic        stb2_q;

    // Mantissa is offset binary; the 16-bit subtraction yields the correctly signed value
    // and bits shifted past bit 15 are never significant for the legal range.
    function automatic logic [15:0] decode(input logic [15:0] w);
        logic [2:0]  e;
        logic [15:0] m_s;
        e   = w[15:13];
        m_s = {6'b0, w[12:3]} - 16'd512;
        if (e == 3'd0) begin
            return 16'h0000;
        end
        return m_s << (e - 3'd1);
    endfunction

    assign tick  = ~i_phi1_NCEN_n;
    assign fall1 = tick & sh1_q & ~i_SH1;
    assign fall2 = tick & sh2_q & ~i_SH2;
    assign latch = fall1 | fall2;
    assign pcm   = decode(sr_q);
    assign upd1  = fall1 & frame_ok;
    assign upd2  = fall2 & frame_ok;

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            sr_q  <= 16'h0000;
            sh1_q <= 1'b0;
            sh2_q <= 1'b0;
        end else if (tick) begin
            sr_q  <= {i_SO, sr_q[15:1]};
            sh1_q <= i_SH1;
            sh2_q <= i_SH2;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            ch1_q  <= 16'h0000;
            ch2_q  <= 16'h0000;
            stb1_q <= 1'b0;
            stb2_q <= 1'b0;
        end else begin
            stb1_q <= upd1;
            stb2_q <= upd2;
            if (upd1) begin
                ch1_q <= pcm;
            end
            if (upd2) begin
                ch2_q <= pcm;
            end
        end
    end

`ifdef IKA3012_FRAME_CHECK_EN
    logic [4:0] cnt_q;
    logic       err_q;

    // Reload with 1 on a latch: the latch tick's own bit starts the next frame.
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            cnt_q <= 5'd0;
            err_q <= 1'b0;
        end else if (tick) begin
            if (latch) begin
                cnt_q <= 5'd1;
                err_q <= ~frame_ok;
            end else if (cnt_q != 5'd31) begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign frame_ok    = (cnt_q == 5'd16);
    assign o_FRAME_ERR = err_q;
`else
    assign frame_ok    = 1'b1;
    assign o_FRAME_ERR = 1'b0;
`endif

    assign o_CH1     = ch1_q;
    assign o_CH2     = ch2_q;
    assign o_CH1_STB = stb1_q;
    assign o_CH2_STB = stb2_q;

endmodule
